// File: rtl/decode_out_pkg.sv
// Shared types and constants for the decode output buffer.
package decode_out_pkg;

  localparam int unsigned E_CONTROL_W = 6;
  localparam int unsigned W_CONTROL_W = 2;
  localparam int unsigned NPC_W       = 16;
  localparam int unsigned INSTR_W     = 16;

  // One decoded instruction as handed from decode to execute.
  typedef struct packed {
    logic [E_CONTROL_W-1:0] E_control;
    logic                   Mem_control;
    logic [NPC_W-1:0]       npc;
    logic [INSTR_W-1:0]     IR;
    logic [W_CONTROL_W-1:0] W_control;
  } decode_out_t;

  // Pipeline bubble: every control bit off, no instruction, no pc.
  localparam decode_out_t DECODE_OUT_NOP = '0;

  // Pointer width for a DEPTH-entry ring; a single entry still needs one bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/decode_out_mem.sv
// DEPTH-entry register array: one synchronous write port, combinational read.
module decode_out_mem
  import decode_out_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ADDR_W = 1,
  parameter type         entry_t = decode_out_t
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  entry_t            wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output entry_t            rd_data
);

  entry_t slots [DEPTH];

  // Storage is deliberately unreset; occupancy alone decides what is valid.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      slots[wr_addr] <= wr_data;
    end
  end

  // Head entry is visible straight from storage.
  always_comb begin
    rd_data = slots[rd_addr];
  end

endmodule

// File: rtl/decode_out_buffer.sv
// FIFO of decode results between the decode and execute stages.
module decode_out_buffer
  import decode_out_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PC_W  = 16,
  parameter int unsigned IR_W  = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [E_CONTROL_W-1:0]       in_E_control,
  input  logic                         in_Mem_control,
  input  logic [PC_W-1:0]              in_npc,
  input  logic [IR_W-1:0]              in_IR,
  input  logic [W_CONTROL_W-1:0]       in_W_control,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [E_CONTROL_W-1:0]       E_control,
  output logic                         Mem_control,
  output logic [PC_W-1:0]              npc_out,
  output logic [IR_W-1:0]              IR,
  output logic [W_CONTROL_W-1:0]       W_control,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL      = CNT_W'(DEPTH);

  // Same field layout as decode_out_t, sized by this instance's widths.
  typedef struct packed {
    logic [E_CONTROL_W-1:0] E_control;
    logic                   Mem_control;
    logic [PC_W-1:0]        npc;
    logic [IR_W-1:0]        IR;
    logic [W_CONTROL_W-1:0] W_control;
  } entry_t;

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] occ;
  logic             push;
  logic             pop;
  entry_t           wr_entry;
  entry_t           head;

  // Explicit wrap keeps non-power-of-two depths inside the array.
  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshakes come from registered occupancy only; flush blocks both sides.
  always_comb begin
    in_ready  = (occ < FULL);
    out_valid = (occ != '0);
    push      = in_valid && in_ready && !flush;
    pop       = out_valid && out_ready && !flush;
    count     = occ;
  end

  // Fields are stored untouched.
  always_comb begin
    wr_entry.E_control   = in_E_control;
    wr_entry.Mem_control = in_Mem_control;
    wr_entry.npc         = in_npc;
    wr_entry.IR          = in_IR;
    wr_entry.W_control   = in_W_control;
  end

  // Pointer and occupancy update; reset beats flush, flush beats push/pop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= bump(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= bump(rd_ptr);
      end
      case ({push, pop})
        2'b10:   occ <= occ + CNT_W'(1);
        2'b01:   occ <= occ - CNT_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  decode_out_mem #(
    .DEPTH   (DEPTH),
    .ADDR_W  (PTR_W),
    .entry_t (entry_t)
  ) u_mem (
    .clock   (clock),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr),
    .rd_data (head)
  );

  // Head fields when valid, otherwise a NOP bubble.
  always_comb begin
    if (out_valid) begin
      E_control   = head.E_control;
      Mem_control = head.Mem_control;
      npc_out     = head.npc;
      IR          = head.IR;
      W_control   = head.W_control;
    end else begin
      E_control   = DECODE_OUT_NOP.E_control;
      Mem_control = DECODE_OUT_NOP.Mem_control;
      npc_out     = '0;
      IR          = '0;
      W_control   = DECODE_OUT_NOP.W_control;
    end
  end

endmodule

// File: tb/tb_decode_out_buffer.sv
// Bench for decode_out_buffer: three depths (2, 3, 1) against a queue model.
module tb_decode_out_buffer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Shared producer data; each DUT has its own handshake/flush controls.
  logic [5:0]  d_e;
  logic        d_m;
  logic [15:0] d_npc;
  logic [15:0] d_ir;
  logic [1:0]  d_w;

  logic        iv   [3];
  logic        ordy [3];
  logic        fl   [3];
  logic        rdy  [3];
  logic        ov   [3];
  logic [5:0]  o_e  [3];
  logic        o_m  [3];
  logic [15:0] o_npc[3];
  logic [15:0] o_ir [3];
  logic [1:0]  o_w  [3];
  logic [1:0]  a_cnt;
  logic [1:0]  b_cnt;
  logic        c_cnt;

  int          n_checks = 0;
  int          n_err    = 0;
  int          dep [3]  = '{2, 3, 1};
  bit          acc [3];
  logic [40:0] q0[$];
  logic [40:0] q1[$];
  logic [40:0] q2[$];

  decode_out_buffer #(.DEPTH(2), .PC_W(16), .IR_W(16)) dut_a (
    .clock(clk), .reset(rst), .in_valid(iv[0]), .in_ready(rdy[0]),
    .in_E_control(d_e), .in_Mem_control(d_m), .in_npc(d_npc), .in_IR(d_ir),
    .in_W_control(d_w), .flush(fl[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .E_control(o_e[0]), .Mem_control(o_m[0]), .npc_out(o_npc[0]), .IR(o_ir[0]),
    .W_control(o_w[0]), .count(a_cnt));

  decode_out_buffer #(.DEPTH(3), .PC_W(16), .IR_W(16)) dut_b (
    .clock(clk), .reset(rst), .in_valid(iv[1]), .in_ready(rdy[1]),
    .in_E_control(d_e), .in_Mem_control(d_m), .in_npc(d_npc), .in_IR(d_ir),
    .in_W_control(d_w), .flush(fl[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .E_control(o_e[1]), .Mem_control(o_m[1]), .npc_out(o_npc[1]), .IR(o_ir[1]),
    .W_control(o_w[1]), .count(b_cnt));

  decode_out_buffer #(.DEPTH(1), .PC_W(16), .IR_W(16)) dut_c (
    .clock(clk), .reset(rst), .in_valid(iv[2]), .in_ready(rdy[2]),
    .in_E_control(d_e), .in_Mem_control(d_m), .in_npc(d_npc), .in_IR(d_ir),
    .in_W_control(d_w), .flush(fl[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
    .E_control(o_e[2]), .Mem_control(o_m[2]), .npc_out(o_npc[2]), .IR(o_ir[2]),
    .W_control(o_w[2]), .count(c_cnt));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cnt_of(input int i);
    case (i)
      0:       return 32'(a_cnt);
      1:       return 32'(b_cnt);
      default: return 32'(c_cnt);
    endcase
  endfunction

  function automatic int q_size(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [40:0] q_front(input int i);
    case (i)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic q_push(input int i, input logic [40:0] v);
    case (i)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  task automatic q_pop(input int i);
    case (i)
      0:       void'(q0.pop_front());
      1:       void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endtask

  task automatic q_clear(input int i);
    case (i)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endtask

  task automatic set_data(input logic [15:0] npc, input logic [15:0] ir);
    d_npc = npc;
    d_ir  = ir;
    d_e   = ir[11:6];
    d_m   = ir[0];
    d_w   = npc[1:0];
  endtask

  // One clock: check every DUT at the falling edge, advance the model at the rising edge.
  task automatic clk_step();
    bit          do_push [3];
    bit          do_pop  [3];
    int          n;
    logic [40:0] exp_head;
    @(negedge clk);
    if (rst) begin
      for (int i = 0; i < 3; i++) q_clear(i);
    end
    for (int i = 0; i < 3; i++) begin
      n        = q_size(i);
      exp_head = (n != 0) ? q_front(i) : '0;
      check($sformatf("in_ready[%0d]", i), 64'(rdy[i]), 64'(n < dep[i]));
      check($sformatf("out_valid[%0d]", i), 64'(ov[i]), 64'(n != 0));
      check($sformatf("count[%0d]", i), 64'(cnt_of(i)), 64'(n));
      check($sformatf("head[%0d]", i), 64'({o_e[i], o_m[i], o_npc[i], o_ir[i], o_w[i]}), 64'(exp_head));
      do_push[i] = !rst && !fl[i] && iv[i] && (n < dep[i]);
      do_pop[i]  = !rst && !fl[i] && ordy[i] && (n != 0);
      acc[i]     = do_push[i];
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (rst || fl[i]) begin
        q_clear(i);
      end else begin
        if (do_pop[i]) q_pop(i);
        if (do_push[i]) q_push(i, {d_e, d_m, d_npc, d_ir, d_w});
      end
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int steps;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b0; fl[i] = 1'b0;
    end
    set_data(16'h0000, 16'h0000);

    // Reset with a push attempt that must be ignored
    set_data(16'h0bad, 16'h0bad);
    iv[0] = 1'b1;
    clk_step();
    clk_step();
    check("rst_no_push", 64'(a_cnt), 64'd0);
    iv[0] = 1'b0;
    rst   = 1'b0;
    clk_step();

    // Single transfer on depth 2
    ordy[0] = 1'b1;
    set_data(16'h3001, 16'h1234);
    iv[0] = 1'b1;
    clk_step();
    iv[0] = 1'b0;
    check("t1_valid", 64'(ov[0]), 64'd1);
    check("t1_ir", 64'(o_ir[0]), 64'h1234);
    check("t1_npc", 64'(o_npc[0]), 64'h3001);
    clk_step();
    clk_step();
    check("t1_empty", 64'(a_cnt), 64'd0);

    // Fill and backpressure on depth 2
    ordy[0] = 1'b0;
    for (int j = 0; j < 3; j++) begin
      set_data(16'h4000 + 16'(j), 16'ha000 + 16'(j));
      iv[0] = 1'b1;
      clk_step();
    end
    check("t2_full_count", 64'(a_cnt), 64'd2);
    check("t2_full_ready", 64'(rdy[0]), 64'd0);
    ordy[0] = 1'b1;
    for (int t = 0; t < 10 && iv[0]; t++) begin
      clk_step();
      if (acc[0]) iv[0] = 1'b0;
    end
    check("t2_third_taken", 64'(iv[0]), 64'd0);
    for (int t = 0; t < 3; t++) clk_step();
    check("t2_drained", 64'(a_cnt), 64'd0);

    // Streaming on depth 3 with pointers wrapping
    ordy[1] = 1'b0;
    for (int j = 0; j < 2; j++) begin
      set_data(16'h5100 + 16'(j), 16'hb100 + 16'(j));
      iv[1] = 1'b1;
      clk_step();
    end
    ordy[1] = 1'b1;
    for (int j = 0; j < 10; j++) begin
      set_data(16'h5000 + 16'(j), 16'hb000 + 16'(j));
      clk_step();
      check($sformatf("t3_count_%0d", j), 64'(b_cnt), 64'd2);
    end
    iv[1] = 1'b0;
    for (int t = 0; t < 3; t++) clk_step();
    check("t3_drained", 64'(b_cnt), 64'd0);

    // Flush with a concurrent push on depth 2
    ordy[0] = 1'b0;
    for (int j = 0; j < 2; j++) begin
      set_data(16'h6100 + 16'(j), 16'hc100 + 16'(j));
      iv[0] = 1'b1;
      clk_step();
    end
    set_data(16'h6000, 16'hc000);
    fl[0] = 1'b1;
    clk_step();
    fl[0] = 1'b0;
    iv[0] = 1'b0;
    check("t4_count", 64'(a_cnt), 64'd0);
    check("t4_valid", 64'(ov[0]), 64'd0);
    check("t4_ir_nop", 64'(o_ir[0]), 64'd0);
    check("t4_npc_nop", 64'(o_npc[0]), 64'd0);
    clk_step();

    // Asynchronous reset mid-operation
    set_data(16'h6800, 16'hc800);
    iv[0] = 1'b1;
    clk_step();
    iv[0] = 1'b0;
    check("t5_pre_count", 64'(a_cnt), 64'd1);
    rst = 1'b1;
    #1;
    check("t5_valid", 64'(ov[0]), 64'd0);
    check("t5_ready", 64'(rdy[0]), 64'd1);
    check("t5_count", 64'(a_cnt), 64'd0);
    clk_step();
    rst = 1'b0;
    clk_step();

    // Depth 1 back-to-back: one entry every two cycles
    ordy[2] = 1'b1;
    k       = 0;
    steps   = 0;
    while (k < 4 && steps < 20) begin
      set_data(16'h7000 + 16'(k), 16'hd000 + 16'(k));
      iv[2] = 1'b1;
      clk_step();
      steps++;
      if (acc[2]) k++;
    end
    iv[2] = 1'b0;
    check("t6_accepted", 64'(k), 64'd4);
    check("t6_steps", 64'(steps), 64'd7);
    check("t6_full_ready", 64'(rdy[2]), 64'd0);
    clk_step();
    clk_step();
    check("t6_drained", 64'(c_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
